// File: rtl/ram_responder_if.sv
// CPU memory port and program-load stream between the core
// and its memory-side responder.
interface ram_responder_if #(
    parameter int SIZE = 10
);
    logic            wrEn;
    logic [SIZE-1:0] addr_toRAM;
    logic [31:0]     data_toRAM;
    logic [31:0]     data_fromRAM;
    logic            ld_valid;
    logic [31:0]     ld_data;
    logic            ld_last;
    logic            ld_ready;
    logic            cpu_run;
    logic [SIZE:0]   load_count;

    modport master (
        output wrEn, addr_toRAM, data_toRAM,
        output ld_valid, ld_data, ld_last,
        input  data_fromRAM, ld_ready,
        input  cpu_run, load_count
    );

    modport slave (
        input  wrEn, addr_toRAM, data_toRAM,
        input  ld_valid, ld_data, ld_last,
        output data_fromRAM, ld_ready,
        output cpu_run, load_count
    );
endinterface

// File: rtl/ram_responder.sv
// Word RAM behind the CPU memory port: cleared and program-loaded
// after reset, then served with a 1-cycle read-first access.
module ram_responder #(
    parameter int SIZE         = 10,
    parameter bit CLEAR_ON_RST = 1'b1
) (
    input logic            clk,
    input logic            rst,
    ram_responder_if.slave bus
);
    localparam int DEPTH = 2 ** SIZE;
    localparam logic [SIZE:0] LAST_IDX = (SIZE + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        CLEAR,
        LOAD,
        RUN
    } state_t;

    state_t          state;
    logic [SIZE-1:0] clrPtr;
    logic [SIZE:0]   loadCount;
    logic            ldReady;
    logic            cpuRun;
    logic [31:0]     rdData;
    logic [31:0]     mem [DEPTH];

    logic            xfer;
    logic            memWe;
    logic [SIZE-1:0] memAddr;
    logic [31:0]     memWd;

    assign xfer = bus.ld_valid & ldReady;

    // One shared write port, owned by whichever phase is active.
    always_comb begin
        memWe   = 1'b0;
        memAddr = '0;
        memWd   = '0;
        unique case (state)
            CLEAR: begin
                memWe   = 1'b1;
                memAddr = clrPtr;
            end
            LOAD: begin
                memWe   = xfer;
                memAddr = loadCount[SIZE-1:0];
                memWd   = bus.ld_data;
            end
            RUN: begin
                memWe   = bus.wrEn;
                memAddr = bus.addr_toRAM;
                memWd   = bus.data_toRAM;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (memWe && !rst) begin
            mem[memAddr] <= memWd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR_ON_RST ? CLEAR : LOAD;
            clrPtr    <= '0;
            loadCount <= '0;
            ldReady   <= 1'b0;
            cpuRun    <= 1'b0;
            rdData    <= '0;
        end else begin
            rdData <= '0;
            unique case (state)
                CLEAR: begin
                    clrPtr <= clrPtr + 1'b1;
                    if (clrPtr == '1) begin
                        state   <= LOAD;
                        ldReady <= 1'b1;
                    end
                end
                LOAD: begin
                    ldReady <= 1'b1;
                    if (xfer) begin
                        loadCount <= loadCount + 1'b1;
                        // A full image ends the load even without ld_last.
                        if (bus.ld_last || loadCount == LAST_IDX) begin
                            state   <= RUN;
                            ldReady <= 1'b0;
                            cpuRun  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    rdData <= mem[bus.addr_toRAM];
                end
                default: ;
            endcase
        end
    end

    assign bus.data_fromRAM = rdData;
    assign bus.ld_ready     = ldReady;
    assign bus.cpu_run      = cpuRun;
    assign bus.load_count   = loadCount;
endmodule
